// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, multi-cycle EX wait,
// taken-branch flushes, EX/MEM + MEM/WB operand forwarding and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW         = 5,
    parameter int LOAD_STALLS    = 1,
    parameter int BR_FLUSH_DEPTH = 3,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mc_start,
    input  logic              ex_mc_done,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              br_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              ex_hold,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MC_WAIT    = 2'b10
    } state_t;

    localparam int                CTR_W      = 3;
    localparam logic [CTR_W-1:0]  STALL_INIT = CTR_W'(LOAD_STALLS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_AW-1:0] REG_ZERO   = {REG_AW{1'b0}};
    localparam logic              FLUSH_IDEX = (BR_FLUSH_DEPTH >= 2);
    localparam logic              FLUSH_EXMM = (BR_FLUSH_DEPTH >= 3);

    state_t              r_state;
    logic [CTR_W-1:0]    r_stall_ctr;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [REG_AW-1:0]   r_ex_rs1;
    logic [REG_AW-1:0]   r_ex_rs2;

    state_t              w_nxt_state;
    logic [CTR_W-1:0]    w_nxt_ctr;
    logic                w_load_use;
    logic                w_pc_write;
    logic                w_if_id_write;
    logic                w_bubble;
    logic                w_hold;
    logic                w_flush_if_id;
    logic                w_flush_id_ex;
    logic                w_flush_ex_mem;
    logic [1:0]          w_fwd_a;
    logic [1:0]          w_fwd_b;

    assign w_load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    // Next-state and pipeline-control decode; reset > branch > multi-cycle > load-use.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_ctr      = r_stall_ctr;
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_bubble       = 1'b0;
        w_hold         = 1'b0;
        w_flush_if_id  = 1'b0;
        w_flush_id_ex  = 1'b0;
        w_flush_ex_mem = 1'b0;
        if (!rst_n) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_bubble       = 1'b1;
            w_flush_if_id  = 1'b1;
            w_flush_id_ex  = 1'b1;
            w_flush_ex_mem = 1'b1;
            w_nxt_state    = ST_RUN;
            w_nxt_ctr      = {CTR_W{1'b0}};
        end else if (br_taken) begin
            w_flush_if_id  = 1'b1;
            w_flush_id_ex  = FLUSH_IDEX;
            w_flush_ex_mem = FLUSH_EXMM;
            w_nxt_state    = ST_RUN;
            w_nxt_ctr      = {CTR_W{1'b0}};
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ex_mc_start && !ex_mc_done) begin
                        w_hold        = 1'b1;
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_nxt_state   = ST_MC_WAIT;
                    end else if (w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_bubble      = 1'b1;
                        if (LOAD_STALLS > 1) begin
                            w_nxt_state = ST_LOAD_STALL;
                            w_nxt_ctr   = STALL_INIT;
                        end else begin
                            w_nxt_state = ST_RUN;
                        end
                    end else begin
                        w_nxt_state = ST_RUN;
                    end
                end
                ST_LOAD_STALL: begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_bubble      = 1'b1;
                    if (r_stall_ctr <= 3'd1) begin
                        w_nxt_state = ST_RUN;
                        w_nxt_ctr   = {CTR_W{1'b0}};
                    end else begin
                        w_nxt_ctr   = r_stall_ctr - 3'd1;
                    end
                end
                ST_MC_WAIT: begin
                    if (ex_mc_done) begin
                        w_nxt_state = ST_RUN;
                    end else begin
                        w_hold        = 1'b1;
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                    end
                end
                default: begin
                    w_nxt_state = ST_RUN;
                    w_nxt_ctr   = {CTR_W{1'b0}};
                end
            endcase
        end
    end

    // Operand forward selects; the EX/MEM result is the younger value so it wins over MEM/WB.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (!rst_n) begin
            w_fwd_a = 2'b00;
            w_fwd_b = 2'b00;
        end else begin
            if (mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == r_ex_rs1)) begin
                w_fwd_a = 2'b10;
            end else if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == r_ex_rs1)) begin
                w_fwd_a = 2'b01;
            end else begin
                w_fwd_a = 2'b00;
            end
            if (mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == r_ex_rs2)) begin
                w_fwd_b = 2'b10;
            end else if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == r_ex_rs2)) begin
                w_fwd_b = 2'b01;
            end else begin
                w_fwd_b = 2'b00;
            end
        end
    end

    // State, stall counter, perf counters and the ID/EX copy of the source registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_stall_ctr <= {CTR_W{1'b0}};
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
            r_ex_rs1    <= REG_ZERO;
            r_ex_rs2    <= REG_ZERO;
        end else begin
            r_state     <= w_nxt_state;
            r_stall_ctr <= w_nxt_ctr;
            if (!w_pc_write && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (br_taken && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
            // A bubble or flush leaves ID/EX empty, so nothing there may request forwarding.
            if (w_flush_id_ex || w_bubble) begin
                r_ex_rs1 <= REG_ZERO;
                r_ex_rs2 <= REG_ZERO;
            end else if (!w_hold) begin
                r_ex_rs1 <= id_rs1;
                r_ex_rs2 <= id_rs2;
            end
        end
    end

    assign pc_write     = w_pc_write;
    assign if_id_write  = w_if_id_write;
    assign id_ex_bubble = w_bubble;
    assign ex_hold      = w_hold;
    assign flush_if_id  = w_flush_if_id;
    assign flush_id_ex  = w_flush_id_ex;
    assign flush_ex_mem = w_flush_ex_mem;
    assign fwd_a        = w_fwd_a;
    assign fwd_b        = w_fwd_b;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign state        = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic, all checked
// against a remaining-stall-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int AW   = 5;
    localparam int LS   = 2;
    localparam int BD   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_mc_start, ex_mc_done;
    logic          mem_reg_write, wb_reg_write, br_taken;
    logic          pc_write, if_id_write, id_ex_bubble, ex_hold;
    logic          flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]    fwd_a, fwd_b, state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(
        .REG_AW(AW), .LOAD_STALLS(LS), .BR_FLUSH_DEPTH(BD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .br_taken(br_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remaining forced-stall cycles plus a "waiting on mul/div" flag.
    int m_stall_left, m_scnt, m_fcnt, m_rs1, m_rs2;
    bit m_in_mc;
    int e_pc, e_ifid, e_bub, e_hold, e_f1, e_f2, e_f3, e_fa, e_fb, e_state;
    int nx_left;
    bit nx_mc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int fwd_sel(input int rs);
        if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == rs) return 2;
        if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == rs) return 1;
        return 0;
    endfunction

    task automatic model_eval();
        bit lu;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e_pc = 1; e_ifid = 1; e_bub = 0; e_hold = 0; e_f1 = 0; e_f2 = 0; e_f3 = 0;
        nx_left = m_stall_left; nx_mc = m_in_mc;
        if (!rst_n) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; e_f1 = 1; e_f2 = 1; e_f3 = 1;
            nx_left = 0; nx_mc = 0;
        end else if (br_taken) begin
            e_f1 = 1; e_f2 = (BD >= 2) ? 1 : 0; e_f3 = (BD >= 3) ? 1 : 0;
            nx_left = 0; nx_mc = 0;
        end else if (m_in_mc) begin
            if (ex_mc_done) nx_mc = 0;
            else begin e_hold = 1; e_pc = 0; e_ifid = 0; end
        end else if (m_stall_left > 0) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; nx_left = m_stall_left - 1;
        end else if (ex_mc_start && !ex_mc_done) begin
            e_hold = 1; e_pc = 0; e_ifid = 0; nx_mc = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; nx_left = LS - 1;
        end
        e_state = m_in_mc ? 2 : ((m_stall_left > 0) ? 1 : 0);
        e_fa = rst_n ? fwd_sel(m_rs1) : 0;
        e_fb = rst_n ? fwd_sel(m_rs2) : 0;
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            m_scnt = 0; m_fcnt = 0; m_rs1 = 0; m_rs2 = 0;
        end else begin
            if (e_pc == 0 && m_scnt < CMAX) m_scnt++;
            if (br_taken && m_fcnt < CMAX) m_fcnt++;
            if (e_f2 == 1 || e_bub == 1) begin m_rs1 = 0; m_rs2 = 0; end
            else if (e_hold == 0) begin m_rs1 = int'(id_rs1); m_rs2 = int'(id_rs2); end
        end
        m_stall_left = nx_left;
        m_in_mc = nx_mc;
    endtask

    task automatic tick_check();
        @(negedge clk);
        model_eval();
        check_eq("pc_write", 32'(pc_write), e_pc);
        check_eq("if_id_write", 32'(if_id_write), e_ifid);
        check_eq("id_ex_bubble", 32'(id_ex_bubble), e_bub);
        check_eq("ex_hold", 32'(ex_hold), e_hold);
        check_eq("flush_if_id", 32'(flush_if_id), e_f1);
        check_eq("flush_id_ex", 32'(flush_id_ex), e_f2);
        check_eq("flush_ex_mem", 32'(flush_ex_mem), e_f3);
        check_eq("fwd_a", 32'(fwd_a), e_fa);
        check_eq("fwd_b", 32'(fwd_b), e_fb);
        check_eq("state", 32'(state), e_state);
        check_eq("stall_cnt", 32'(stall_cnt), m_scnt);
        check_eq("flush_cnt", 32'(flush_cnt), m_fcnt);
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic step();
        tick_check();
        advance();
    endtask

    task automatic clear_inputs();
        rst_n = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_mc_start = 1'b0; ex_mc_done = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0; br_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        m_stall_left = 0; m_in_mc = 0; m_scnt = 0; m_fcnt = 0; m_rs1 = 0; m_rs2 = 0;
        @(posedge clk); #1;

        // Reset: two cycles low, then release idle
        step(); step();
        rst_n = 1'b1;
        tick_check();
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_stall_cnt", 32'(stall_cnt), 0);
        check_eq("rst_flush_cnt", 32'(flush_cnt), 0);
        check_eq("rst_pc_write", 32'(pc_write), 1);
        check_eq("rst_fwd_a", 32'(fwd_a), 0);
        check_eq("rst_fwd_b", 32'(fwd_b), 0);
        advance();

        // Forward priority
        id_rs1 = 5'd5; id_rs2 = 5'd9;
        step();
        mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        tick_check(); check_eq("fwd_prio_exmem", 32'(fwd_a), 2); advance();
        mem_reg_write = 1'b0;
        tick_check(); check_eq("fwd_wb", 32'(fwd_a), 1); advance();
        wb_rd = 5'd9;
        tick_check(); check_eq("fwd_b_wb", 32'(fwd_b), 1); advance();
        id_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1;
        step();
        tick_check(); check_eq("fwd_x0", 32'(fwd_a), 0); advance();
        clear_inputs();
        step();

        // Load-use with two stall cycles
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        tick_check();
        check_eq("lu0_pc", 32'(pc_write), 0); check_eq("lu0_bub", 32'(id_ex_bubble), 1);
        check_eq("lu0_state", 32'(state), 0);
        advance();
        clear_inputs();
        tick_check();
        check_eq("lu1_pc", 32'(pc_write), 0); check_eq("lu1_bub", 32'(id_ex_bubble), 1);
        check_eq("lu1_state", 32'(state), 1);
        advance();
        tick_check();
        check_eq("lu2_state", 32'(state), 0); check_eq("lu2_pc", 32'(pc_write), 1);
        check_eq("lu2_stall_cnt", 32'(stall_cnt), 2);
        advance();

        // Multi-cycle op finishing four cycles after start
        do_reset();
        ex_mc_start = 1'b1;
        tick_check(); check_eq("mc0_hold", 32'(ex_hold), 1); check_eq("mc0_bub", 32'(id_ex_bubble), 0); advance();
        ex_mc_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_check();
            check_eq("mc_hold", 32'(ex_hold), 1); check_eq("mc_state", 32'(state), 2);
            check_eq("mc_bub", 32'(id_ex_bubble), 0);
            advance();
        end
        ex_mc_done = 1'b1;
        tick_check(); check_eq("mc_done_hold", 32'(ex_hold), 0); check_eq("mc_done_pc", 32'(pc_write), 1); advance();
        ex_mc_done = 1'b0;
        tick_check(); check_eq("mc_end_state", 32'(state), 0); check_eq("mc_stall_cnt", 32'(stall_cnt), 4); advance();

        // Branch while waiting on a multi-cycle op
        do_reset();
        ex_mc_start = 1'b1; step();
        ex_mc_start = 1'b0; step();
        br_taken = 1'b1;
        tick_check();
        check_eq("br_fl_if_id", 32'(flush_if_id), 1); check_eq("br_fl_id_ex", 32'(flush_id_ex), 1);
        check_eq("br_fl_ex_mem", 32'(flush_ex_mem), 0); check_eq("br_pc", 32'(pc_write), 1);
        advance();
        br_taken = 1'b0;
        tick_check(); check_eq("br_state", 32'(state), 0); check_eq("br_flush_cnt", 32'(flush_cnt), 1); advance();

        // Stall counter saturation
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        for (int i = 0; i < 40; i++) step();
        tick_check(); check_eq("sat_stall_cnt", 32'(stall_cnt), CMAX); advance();
        for (int i = 0; i < 5; i++) step();
        tick_check(); check_eq("sat_hold", 32'(stall_cnt), CMAX); advance();
        clear_inputs();

        // Random traffic with occasional mid-operation resets
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 99) >= 3);
            id_rs1        = AW'($urandom_range(0, 3));
            id_rs2        = AW'($urandom_range(0, 3));
            id_use_rs1    = ($urandom_range(0, 1) == 1);
            id_use_rs2    = ($urandom_range(0, 1) == 1);
            ex_rd         = AW'($urandom_range(0, 3));
            ex_mem_read   = ($urandom_range(0, 9) < 4);
            ex_mc_start   = ($urandom_range(0, 9) < 2);
            ex_mc_done    = ($urandom_range(0, 9) < 3);
            mem_rd        = AW'($urandom_range(0, 3));
            mem_reg_write = ($urandom_range(0, 1) == 1);
            wb_rd         = AW'($urandom_range(0, 3));
            wb_reg_write  = ($urandom_range(0, 1) == 1);
            br_taken      = ($urandom_range(0, 9) < 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
